product_display: RTL and testbench



---
 rtl/product_display_pkg.sv | 40 ++++
 rtl/bin_to_bcd_seq.sv | 83 ++++++++
 rtl/product_display.sv | 108 ++++++++++
 tb/tb_product_display.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/product_display_pkg.sv
// product_display_pkg
// Shared types and constants for the product display block: converter FSM
// states, datapath widths and the active-low seven-segment glyph table.
package product_display_pkg;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 8;
    localparam int BCD_W      = 12;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Glyphs for 0..9, entry 0 in the least significant position.
    localparam logic [9:0][6:0] SEG_LUT = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Glyph for one BCD digit; non-decimal codes render blank.
    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        if (digit > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_LUT[digit];
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Iterative double-dabble converter: one add-3/shift step per clock, eight
// steps per 8-bit input.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin a conversion of bin (ignored while busy)
//   bin[7:0]    binary value sampled on the start edge
//   busy        high from the start edge until the final step's edge
//   done        high during the clock whose edge performs the final step
//   bcd[11:0]   {hundreds, tens, ones}; valid while done is high
module bin_to_bcd_seq
    import product_display_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    state_t             state;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   acc;
    logic [2:0]         iter;

    logic [BCD_W-1:0]   adj;
    logic [19:0]        shifted;

    // NOTE: every output of an always_comb block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        adj = acc;
        for (int n = 0; n < 3; n++) begin
            if (acc[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
            end
        end
        // The accumulator never exceeds 255, so the bit shifted out is zero.
        shifted = {adj, bin_sr} << 1;
    end

    // done is combinational so the consumer can capture the shifted result on
    // the same edge that performs the final step.
    assign done = (state == CONVERT) && (iter == 3'd7);
    assign bcd  = shifted[19:8];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            bin_sr <= '0;
            acc    <= '0;
            iter   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        acc    <= '0;
                        iter   <= '0;
                        busy   <= 1'b1;
                        state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc    <= shifted[19:8];
                    bin_sr <= shifted[7:0];
                    iter   <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/product_display.sv
// product_display
// Captures the multiplier product on each rising edge of done, converts it to
// three BCD digits and scans them onto a 4-digit active-low seven-segment
// display with leading-zero blanking.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   P[7:0]      product from the multiplier
//   done        multiplier completion; rising edge starts a capture
//   busy        conversion in progress
//   valid       at least one conversion has completed since reset
//   an[3:0]     digit anodes, active-low one-hot, an[0] rightmost
//   seg[6:0]    segments {g,f,e,d,c,b,a}, active-low
module product_display
    import product_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] P,
    input  logic       done,
    output logic       busy,
    output logic       valid,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic             done_d;
    logic             rise;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    logic [3:0]       hund;
    logic [3:0]       tens;
    logic [3:0]       ones;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [6:0]       seg_next;

    // A held-high done produces a single rise; rises during a conversion are
    // dropped by the converter rather than queued.
    assign rise = done & ~done_d;

    bin_to_bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (rise),
        .bin   (P),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Digits change only when a conversion finishes, so the previous value
    // stays on the display while the next one is being computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_d <= 1'b0;
            valid  <= 1'b0;
            hund   <= '0;
            tens   <= '0;
            ones   <= '0;
        end else begin
            done_d <= done;
            if (conv_done) begin
                hund  <= conv_bcd[11:8];
                tens  <= conv_bcd[7:4];
                ones  <= conv_bcd[3:0];
                valid <= 1'b1;
            end
        end
    end

    always_comb begin
        seg_next = SEG_BLANK;
        if (valid) begin
            case (digit_idx)
                2'd0: seg_next = seg_of(ones);
                2'd1: if (hund != 4'd0 || tens != 4'd0) seg_next = seg_of(tens);
                2'd2: if (hund != 4'd0) seg_next = seg_of(hund);
                default: seg_next = SEG_BLANK;
            endcase
        end
    end

    // an and seg are registered from the same index so they switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            an  <= ~(4'b0001 << digit_idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_product_display.sv
// tb_product_display
// Directed bench for product_display with a 4-clock refresh slot.
module tb_product_display;

    logic       clk;
    logic       rst_n;
    logic [7:0] P;
    logic       done;
    logic       busy;
    logic       valid;
    logic [3:0] an;
    logic [6:0] seg;

    int errors = 0;
    int checks = 0;
    int rises;
    int hi;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_0     = 7'b1000000;
    localparam logic [6:0] S_1     = 7'b1111001;
    localparam logic [6:0] S_2     = 7'b0100100;
    localparam logic [6:0] S_5     = 7'b0010010;
    localparam logic [6:0] S_7     = 7'b1111000;
    localparam logic [6:0] S_8     = 7'b0000000;

    product_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .P     (P),
        .done  (done),
        .busy  (busy),
        .valid (valid),
        .an    (an),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until the given anode is active (bounded), then confirm it.
    task automatic wait_an(input logic [3:0] a);
        int n = 0;
        while (an !== a && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_an", {28'd0, an}, {28'd0, a});
    endtask

    task automatic show(input string tag, input logic [3:0] a, input logic [6:0] s);
        wait_an(a);
        check(tag, {25'd0, seg}, {25'd0, s});
    endtask

    // Start a capture of p and watch busy for 20 clocks after the capture
    // edge. done is held for `hold` clocks (0 = single pulse); a second done
    // pulse carrying P=99 is injected after observation `reinject` (-1 = none).
    task automatic measure(input logic [7:0] p, input int hold, input int reinject,
                           output int r, output int h);
        logic prev = 1'b0;
        r = 0;
        h = 0;
        P    = p;
        done = 1'b1;
        @(negedge clk);
        if (hold == 0) done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy && !prev) r++;
            if (busy) h++;
            prev = busy;
            if (hold != 0 && i + 1 == hold) done = 1'b0;
            if (i == reinject) begin
                done = 1'b1;
                P    = 8'd99;
            end
            if (reinject >= 0 && i == reinject + 1) done = 1'b0;
            @(negedge clk);
        end
        done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        P     = 8'd0;
        done  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_an",    {28'd0, an},    {28'd0, 4'b1111});
        check("rst_seg",   {25'd0, seg},   {25'd0, S_BLANK});

        // Scan order after release: each anode held 4 clocks, all blank.
        rst_n = 1'b1;
        @(negedge clk);
        check("scan0_an",  {28'd0, an},  {28'd0, 4'b1110});
        check("scan0_seg", {25'd0, seg}, {25'd0, S_BLANK});
        repeat (4) @(negedge clk);
        check("scan1_an",  {28'd0, an},  {28'd0, 4'b1101});
        check("scan1_seg", {25'd0, seg}, {25'd0, S_BLANK});
        repeat (4) @(negedge clk);
        check("scan2_an",  {28'd0, an},  {28'd0, 4'b1011});
        check("scan2_seg", {25'd0, seg}, {25'd0, S_BLANK});
        repeat (4) @(negedge clk);
        check("scan3_an",  {28'd0, an},  {28'd0, 4'b0111});
        check("scan3_seg", {25'd0, seg}, {25'd0, S_BLANK});
        repeat (4) @(negedge clk);
        check("scan4_an",  {28'd0, an},  {28'd0, 4'b1110});
        check("pre_valid", {31'd0, valid}, 32'd0);

        // 255 -> 2 5 5, busy for exactly 8 clocks
        measure(8'd255, 0, -1, rises, hi);
        check("p255_rises", rises, 1);
        check("p255_busy_clks", hi, 8);
        check("p255_valid", {31'd0, valid}, 32'd1);
        show("p255_hund", 4'b1011, S_2);
        show("p255_tens", 4'b1101, S_5);
        show("p255_ones", 4'b1110, S_5);
        show("p255_d3",   4'b0111, S_BLANK);

        // 7: leading zeros blanked
        measure(8'd7, 0, -1, rises, hi);
        show("p7_ones", 4'b1110, S_7);
        show("p7_tens", 4'b1101, S_BLANK);
        show("p7_hund", 4'b1011, S_BLANK);

        // 0: ones still shown
        measure(8'd0, 0, -1, rises, hi);
        check("p0_valid", {31'd0, valid}, 32'd1);
        show("p0_ones", 4'b1110, S_0);
        show("p0_tens", 4'b1101, S_BLANK);
        show("p0_hund", 4'b1011, S_BLANK);

        // 100 with done held 20 clocks: one conversion, inner zero kept
        measure(8'd100, 20, -1, rises, hi);
        check("p100_rises", rises, 1);
        check("p100_busy_clks", hi, 8);
        show("p100_hund", 4'b1011, S_1);
        show("p100_tens", 4'b1101, S_0);
        show("p100_ones", 4'b1110, S_0);

        // 8 with done held 20 clocks
        measure(8'd8, 20, -1, rises, hi);
        check("p8_rises", rises, 1);
        show("p8_ones", 4'b1110, S_8);
        show("p8_tens", 4'b1101, S_BLANK);
        show("p8_hund", 4'b1011, S_BLANK);

        // 128 with a second rise at E3 carrying P=99: ignored
        measure(8'd128, 0, 2, rises, hi);
        check("p128_rises", rises, 1);
        check("p128_busy_clks", hi, 8);
        show("p128_hund", 4'b1011, S_1);
        show("p128_tens", 4'b1101, S_2);
        show("p128_ones", 4'b1110, S_8);

        // 200 with reset asserted before E4: immediate return to reset values
        P    = 8'd200;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        check("p200_busy_mid", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy",  {31'd0, busy},  32'd0);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_an",    {28'd0, an},    {28'd0, 4'b1111});
        check("arst_seg",   {25'd0, seg},   {25'd0, S_BLANK});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_busy",  {31'd0, busy},  32'd0);
        check("post_valid", {31'd0, valid}, 32'd0);
        show("post_ones", 4'b1110, S_BLANK);
        show("post_hund", 4'b1011, S_BLANK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
